// File: rtl/riscv_pkg.sv
// Shared types and constants for the Mini-RISC-V core.
// Holds the fetch FSM state type, the canonical NOP and the PC step.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetch_state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and one-entry hold buffer.
// Ports: clock/reset, hz/redirect(_pc) from decode, imem req/ready/
// rvalid/rdata handshake, IF_ID_valid/pc/inst towards decode.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        hz,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        IF_ID_valid,
   output logic [31:0] IF_ID_pc,
   output logic [31:0] IF_ID_inst
);

   fetch_state_t state;
   fetch_state_t state_nxt;

   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   logic        hold_valid;
   logic [31:0] hold_pc;
   logic [31:0] hold_inst;

   logic rsp_live;
   logic rsp_drop;
   logic accept;

   // A response only matters in WAIT; in DROP it is stale.
   assign rsp_live = (state == WAIT) && imem_rvalid;
   assign rsp_drop = (state == DROP) && imem_rvalid;

   // Issue only once the slot frees up, so at most one is in flight
   // and the hold buffer can never be overrun.
   assign imem_req = !reset && !redirect && !hold_valid &&
                     ((state == IDLE) ||
                      (rsp_live && !hz) ||
                      rsp_drop);

   assign accept    = imem_req && imem_ready;
   assign imem_addr = fetch_pc;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept) state_nxt = WAIT;
         end
         WAIT, DROP: begin
            if (imem_rvalid)
               state_nxt = accept ? WAIT : IDLE;
            else if (redirect)
               state_nxt = DROP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= 32'd0;
      end else begin
         if (accept)
            req_pc <= fetch_pc;
         if (redirect)
            fetch_pc <= redirect_pc;
         else if (accept)
            fetch_pc <= fetch_pc + PC_INC;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hold_valid  <= 1'b0;
         hold_pc     <= 32'd0;
         hold_inst   <= NOP_INST;
         IF_ID_valid <= 1'b0;
         IF_ID_pc    <= 32'd0;
         IF_ID_inst  <= NOP_INST;
      end else if (redirect) begin
         hold_valid  <= 1'b0;
         IF_ID_valid <= 1'b0;
      end else if (hz) begin
         if (rsp_live) begin
            hold_valid <= 1'b1;
            hold_pc    <= req_pc;
            hold_inst  <= imem_rdata;
         end
      end else if (hold_valid) begin
         hold_valid  <= 1'b0;
         IF_ID_valid <= 1'b1;
         IF_ID_pc    <= hold_pc;
         IF_ID_inst  <= hold_inst;
      end else if (rsp_live) begin
         IF_ID_valid <= 1'b1;
         IF_ID_pc    <= req_pc;
         IF_ID_inst  <= imem_rdata;
      end else begin
         IF_ID_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small latency-programmable imem.
// Summary: test done: total/bad.
module tb_fetch_stage;

   logic        clock;
   logic        reset;
   logic        hz;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        IF_ID_valid;
   logic [31:0] IF_ID_pc;
   logic [31:0] IF_ID_inst;

   int n_chk;
   int n_bad;
   int lat;

   logic        m_pend;
   int          m_cnt;
   logic [31:0] m_addr;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_stage #(.RESET_PC(32'h0)) dut (
      .clock      (clock),
      .reset      (reset),
      .hz         (hz),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .IF_ID_valid(IF_ID_valid),
      .IF_ID_pc   (IF_ID_pc),
      .IF_ID_inst (IF_ID_inst)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_pend      <= 1'b0;
         imem_rvalid <= 1'b0;
      end else begin
         imem_rvalid <= 1'b0;
         if (m_pend) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= mem_word(m_addr);
               m_pend      <= 1'b0;
            end
         end
         if (imem_req && imem_ready) begin
            if (lat == 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= mem_word(imem_addr);
            end else begin
               m_pend <= 1'b1;
               m_cnt  <= lat - 1;
               m_addr <= imem_addr;
            end
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_chk       = 0;
      n_bad       = 0;
      lat         = 1;
      m_cnt       = 0;
      m_addr      = 32'd0;
      imem_rdata  = 32'd0;
      reset       = 1'b1;
      hz          = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      imem_ready  = 1'b1;
      tick();
      tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("rst_pc", IF_ID_pc, 32'd0);
      chk("rst_inst", IF_ID_inst, NOP);

      // cycle 0
      reset = 1'b0;
      #1;
      chk("c0_req", {31'd0, imem_req}, 32'd1);
      chk("c0_addr", imem_addr, 32'h0);
      tick(); // 1
      chk("c1_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("c1_addr", imem_addr, 32'h4);
      tick(); // 2
      chk("c2_pc", IF_ID_pc, 32'h0);
      chk("c2_inst", IF_ID_inst, mem_word(32'h0));
      chk("c2_addr", imem_addr, 32'h8);
      tick(); // 3
      chk("c3_pc", IF_ID_pc, 32'h4);
      chk("c3_valid", {31'd0, IF_ID_valid}, 32'd1);
      tick(); // 4
      chk("c4_pc", IF_ID_pc, 32'h8);

      // stall three cycles while 0xC is returning
      hz = 1'b1;
      #1;
      chk("c4_hz_req", {31'd0, imem_req}, 32'd0);
      tick(); // 5
      chk("c5_pc", IF_ID_pc, 32'h8);
      chk("c5_valid", {31'd0, IF_ID_valid}, 32'd1);
      chk("c5_req", {31'd0, imem_req}, 32'd0);
      tick(); // 6
      chk("c6_pc", IF_ID_pc, 32'h8);
      chk("c6_req", {31'd0, imem_req}, 32'd0);
      tick(); // 7
      hz = 1'b0;
      #1;
      chk("c7_req", {31'd0, imem_req}, 32'd0);
      tick(); // 8
      chk("c8_pc", IF_ID_pc, 32'hC);
      chk("c8_inst", IF_ID_inst, mem_word(32'hC));
      chk("c8_valid", {31'd0, IF_ID_valid}, 32'd1);
      chk("c8_addr", imem_addr, 32'h10);
      tick(); // 9
      chk("c9_valid", {31'd0, IF_ID_valid}, 32'd0);
      tick(); // 10
      chk("c10_pc", IF_ID_pc, 32'h10);
      chk("c10_addr", imem_addr, 32'h18);

      // slow memory for 0x18, then redirect while it is in flight
      lat = 3;
      tick(); // 11
      chk("c11_pc", IF_ID_pc, 32'h14);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      #1;
      chk("c11_req", {31'd0, imem_req}, 32'd0);
      tick(); // 12
      redirect = 1'b0;
      lat      = 1;
      #1;
      chk("c12_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("c12_req", {31'd0, imem_req}, 32'd0);
      tick(); // 13
      chk("c13_req", {31'd0, imem_req}, 32'd1);
      chk("c13_addr", imem_addr, 32'h100);
      chk("c13_valid", {31'd0, IF_ID_valid}, 32'd0);
      tick(); // 14
      chk("c14_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("c14_addr", imem_addr, 32'h104);
      tick(); // 15
      chk("c15_pc", IF_ID_pc, 32'h100);
      chk("c15_inst", IF_ID_inst, mem_word(32'h100));

      // stall buffers 0x104, then redirect+hz flushes it
      hz = 1'b1;
      tick(); // 16
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      #1;
      chk("c16_req", {31'd0, imem_req}, 32'd0);
      tick(); // 17
      hz       = 1'b0;
      redirect = 1'b0;
      #1;
      chk("c17_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("c17_req", {31'd0, imem_req}, 32'd1);
      chk("c17_addr", imem_addr, 32'h200);
      tick(); // 18
      chk("c18_valid", {31'd0, IF_ID_valid}, 32'd0);
      tick(); // 19
      chk("c19_pc", IF_ID_pc, 32'h200);
      chk("c19_valid", {31'd0, IF_ID_valid}, 32'd1);

      // memory not ready for four cycles
      imem_ready = 1'b0;
      tick(); // 20
      chk("c20_pc", IF_ID_pc, 32'h204);
      chk("c20_addr", imem_addr, 32'h208);
      tick(); // 21
      chk("c21_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("c21_addr", imem_addr, 32'h208);
      tick(); // 22
      chk("c22_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("c22_addr", imem_addr, 32'h208);
      tick(); // 23
      imem_ready = 1'b1;
      #1;
      chk("c23_addr", imem_addr, 32'h208);
      tick(); // 24
      chk("c24_addr", imem_addr, 32'h20C);
      tick(); // 25
      chk("c25_pc", IF_ID_pc, 32'h208);

      // wrap-around at the top of the address space
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick(); // 26
      redirect = 1'b0;
      #1;
      chk("c26_addr", imem_addr, 32'hFFFF_FFFC);
      chk("c26_valid", {31'd0, IF_ID_valid}, 32'd0);
      tick(); // 27
      chk("c27_addr", imem_addr, 32'h0);
      tick(); // 28
      chk("c28_pc", IF_ID_pc, 32'hFFFF_FFFC);
      chk("c28_inst", IF_ID_inst, mem_word(32'hFFFF_FFFC));

      // reset mid-stream
      reset = 1'b1;
      #1;
      chk("r_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("r_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("r_inst", IF_ID_inst, NOP);
      reset = 1'b0;
      #1;
      chk("r_addr", imem_addr, 32'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the Mini-RISC-V core. Holds the PC, issues single-outstanding requests to instruction memory, and delivers {pc, instruction, valid} to the decode stage. Downstream it consumes the decode-stage hazard stall (`hz`) and the branch/jump redirect; a one-entry hold buffer absorbs a response that returns while decode is stalled.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hz`  in  1  stall from hazard detection; IF/ID must hold.
- `redirect`  in  1  taken branch/jal/jalr resolved in decode.
- `redirect_pc`  in  32  target address; valid when `redirect`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `fetch_pc`.
- `imem_ready`  in  1  request accepted when `imem_req && imem_ready`.
- `imem_rvalid`  in  1  response valid; at least 1 cycle after acceptance.
- `imem_rdata`  in  32  instruction word.
- `IF_ID_valid`  out  1  IF/ID holds a real instruction.
- `IF_ID_pc`  out  32  PC of IF/ID instruction.
- `IF_ID_inst`  out  32  IF/ID instruction.

## Operation
- Registers: `fetch_pc`, `req_pc` (PC of in-flight request), `state`, `hold_valid/hold_pc/hold_inst`, IF/ID.
- FSM states:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding, current path.
  - DROP: one request outstanding, stale after a redirect.
- Issue: `imem_req = !redirect && !hold_valid && (IDLE || (WAIT && imem_rvalid && !hz) || (DROP && imem_rvalid))`.
  - Unaccepted requests are re-evaluated each cycle; the address is unchanged unless a redirect occurs.
  - On acceptance: `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`; 32-bit wrap-around.
- Transitions:
  - IDLE -accept-> WAIT.
  - WAIT -rvalid&accept-> WAIT.
  - WAIT -rvalid&!accept-> IDLE.
  - WAIT -redirect&!rvalid-> DROP.
  - DROP -rvalid&accept-> WAIT.
  - DROP -rvalid&!accept-> IDLE.
  - `imem_rvalid` in IDLE is ignored.
- Redirect (highest priority):
  - `fetch_pc <= redirect_pc`, IF/ID flushed (`IF_ID_valid <= 0`), `hold_valid <= 0`.
  - A response arriving the same cycle is discarded.
  - Redirect overrides `hz` when both are asserted.
- Else, if `hz`: IF/ID unchanged. A WAIT response is written into the hold buffer.
- Else, IF/ID loads, in priority order:
  - the hold buffer (clears `hold_valid`);
  - else a WAIT response (`req_pc`, `imem_rdata`);
  - else a bubble: `IF_ID_valid <= 0`; pc/inst unchanged.
- DROP responses never reach IF/ID or the hold buffer.

## Timing
- Reset values:
  - `fetch_pc=RESET_PC`, `state=IDLE`, `hold_valid=0`.
  - `IF_ID_valid=0`, `IF_ID_pc=0`, `IF_ID_inst=32'h0000_0013` (NOP).
  - `imem_req=0` while `reset`=1.
- Reset mid-operation discards any outstanding response; a response arriving after reset finds IDLE and is ignored.
- First `imem_req` is asserted in the first cycle with `reset`=0.
- Latency, 1-cycle memory: accepted at cycle t, `imem_rvalid` at t+1, `IF_ID_valid` at t+2.
- Throughput: 1 instruction/cycle, back-to-back, when `hz`=0.
- Redirect at cycle t: first request to `redirect_pc` issues at t+1 in IDLE; if stale, after the stale `imem_rvalid`.
- Stall: at most one instruction buffered. No request is issued while `hold_valid`, so no response is ever lost or duplicated.

## Structure
- `riscv_pkg` holds:
  - `fetch_state_t` enum {IDLE, WAIT, DROP};
  - `NOP_INST = 32'h0000_0013`;
  - `PC_INC = 4`.
- Single flat module; no sub-module warranted.

## Test plan
- Reset, 1-cycle imem always ready: requests 0x0, 0x4, 0x8 on consecutive cycles; IF_ID_pc 0x0/0x4/0x8 from cycle 2; IF_ID_valid stays 1.
- `hz`=1 for 3 cycles mid-stream: IF/ID holds its value; the in-flight instruction goes to the hold buffer; `imem_req`=0 while held; on release, the held instruction enters next with no gap and no duplicate.
- `redirect`=1, `redirect_pc`=0x100, while a request is outstanding and `imem_rvalid` is delayed 2 cycles: state DROP; the stale data never appears; next IF_ID_pc=0x100.
- `redirect` and `hz` asserted together: IF_ID_valid=0 next cycle; hold buffer cleared; fetch resumes at the target.
- `imem_ready`=0 for 4 cycles: `imem_addr` stable; `fetch_pc` not incremented; IF_ID_valid=0 bubbles.
- `fetch_pc`=0xFFFF_FFFC accepted: next `imem_addr`=0x0000_0000 (wrap).
